imem_loader: RTL and testbench

Byte-serial loader that fills the byte-addressed instruction memory with program words before the processor runs. It accepts a valid/ready byte stream and packs each group of four bytes into one word, first byte in the most significant position. This matches the fetch side, which returns {mem[a], mem[a+1], mem[a+2], mem[a+3]} from word-aligned address a. It issues one word-wide write per packed word at consecutive word-aligned addresses and reports completion and an XOR checksum.

---
 rtl/imem_loader.sv | 102 ++++++++++
 tb/tb_imem_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-serial instruction memory loader: packs a valid/ready byte stream big-endian
// into 32-bit words and writes them to consecutive word-aligned addresses.
module imem_loader #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      base_addr,
    input  logic [CNT_W-1:0] word_count,
    input  logic             in_valid,
    input  logic [7:0]       in_byte,
    output logic             in_ready,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             busy,
    output logic             done,
    output logic [7:0]       checksum
);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] word_cnt;
    logic [CNT_W-1:0] word_cnt_inc;
    logic [1:0]       byte_cnt;
    logic [31:0]      ptr;
    logic [31:0]      wdata;
    logic [7:0]       csum;
    logic             start_ok;
    logic             accept;

    assign start_ok     = start && ((state == IDLE) || (state == DONE));
    assign accept       = in_valid && (state == RECV);
    assign word_cnt_inc = word_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (start_ok) begin
                    state_next = (word_count != '0) ? RECV : DONE;
                end
            end
            RECV: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                state_next = (word_cnt_inc == count_q) ? DONE : RECV;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pointer and counters advance on the edge that ends the WRITE cycle, so the
    // address shown during mem_we is the one belonging to the current word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            wdata    <= '0;
            csum     <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
            count_q  <= '0;
        end else if (start_ok) begin
            ptr      <= {base_addr[31:2], 2'b00};
            count_q  <= word_count;
            csum     <= '0;
            byte_cnt <= '0;
            word_cnt <= '0;
        end else if (accept) begin
            wdata    <= {wdata[23:0], in_byte};
            csum     <= csum ^ in_byte;
            byte_cnt <= byte_cnt + 2'd1;
        end else if (state == WRITE) begin
            ptr      <= ptr + 32'd4;
            word_cnt <= word_cnt_inc;
        end
    end

    assign in_ready  = (state == RECV);
    assign mem_we    = (state == WRITE);
    assign busy      = (state == RECV) || (state == WRITE);
    assign done      = (state == DONE);
    assign mem_addr  = ptr;
    assign mem_wdata = wdata;
    assign checksum  = csum;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: packing, addressing, stalls,
// alignment/wrap, zero count, ignored start and reset mid-word.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [15:0] word_count;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    int          vectors;
    int          miscompares;
    int          cyc;
    logic        prev_we;
    logic        two_we;
    logic [31:0] we_addr[$];
    logic [31:0] we_data[$];
    int          we_cycle[$];
    logic [7:0]  stream[0:7];

    imem_loader #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .checksum   (checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe and flag any back-to-back strobes.
    always @(negedge clk) begin
        if (mem_we) begin
            we_addr.push_back(mem_addr);
            we_data.push_back(mem_wdata);
            we_cycle.push_back(cyc);
        end
        if (mem_we && prev_we) two_we = 1'b1;
        prev_we = mem_we;
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [31:0] base, input logic [15:0] count);
        we_addr.delete();
        we_data.delete();
        we_cycle.delete();
        base_addr  = base;
        word_count = count;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic feedBytes(input int first, input int n, input int stall);
        for (int i = first; i < first + n; i++) begin
            int waited;
            waited   = 0;
            in_valid = 1'b1;
            in_byte  = stream[i];
            while (!in_ready && waited < 50) begin
                tick();
                waited++;
            end
            if (!in_ready) checkOutput("ready_timeout", {31'd0, in_ready}, 32'd1);
            tick();
            in_valid = 1'b0;
            repeat (stall) tick();
        end
    endtask

    task automatic waitDone();
        int n;
        n = 0;
        while (!done && n < 200) begin
            tick();
            n++;
        end
        if (!done) checkOutput("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic loadWords(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
        stream[0] = b0; stream[1] = b1; stream[2] = b2; stream[3] = b3;
        stream[4] = b4; stream[5] = b5; stream[6] = b6; stream[7] = b7;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        cyc         = 0;
        prev_we     = 1'b0;
        two_we      = 1'b0;
        rst_n       = 1'b0;
        start       = 1'b0;
        base_addr   = '0;
        word_count  = '0;
        in_valid    = 1'b0;
        in_byte     = '0;
        loadWords(8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h08, 8'h00, 8'h00);
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_done", {31'd0, done}, 32'd0);
        checkOutput("rst_we", {31'd0, mem_we}, 32'd0);
        checkOutput("rst_addr", mem_addr, 32'd0);
        checkOutput("rst_wdata", mem_wdata, 32'd0);
        checkOutput("rst_csum", {24'd0, checksum}, 32'd0);

        // Two-word load with in_valid held high.
        applyStimulus(32'h100, 16'd2);
        checkOutput("t2_ready", {31'd0, in_ready}, 32'd1);
        checkOutput("t2_busy", {31'd0, busy}, 32'd1);
        feedBytes(0, 8, 0);
        checkOutput("t2_last_we", {31'd0, mem_we}, 32'd1);
        checkOutput("t2_last_nodone", {31'd0, done}, 32'd0);
        tick();
        checkOutput("t2_done", {31'd0, done}, 32'd1);
        checkOutput("t2_we_off", {31'd0, mem_we}, 32'd0);
        checkOutput("t2_busy_off", {31'd0, busy}, 32'd0);
        checkOutput("t2_nwe", we_addr.size(), 32'd2);
        checkOutput("t2_addr0", we_addr[0], 32'h100);
        checkOutput("t2_data0", we_data[0], 32'h20080005);
        checkOutput("t2_addr1", we_addr[1], 32'h104);
        checkOutput("t2_data1", we_data[1], 32'hAC080000);
        checkOutput("t2_spacing", we_cycle[1] - we_cycle[0], 32'd5);
        checkOutput("t2_csum", {24'd0, checksum}, 32'h89);
        checkOutput("t2_wdata_held", mem_wdata, 32'hAC080000);

        // Same stream with three idle cycles between bytes.
        applyStimulus(32'h100, 16'd2);
        feedBytes(0, 8, 3);
        waitDone();
        repeat (3) tick();
        checkOutput("t3_nwe", we_addr.size(), 32'd2);
        checkOutput("t3_addr0", we_addr[0], 32'h100);
        checkOutput("t3_data0", we_data[0], 32'h20080005);
        checkOutput("t3_addr1", we_addr[1], 32'h104);
        checkOutput("t3_data1", we_data[1], 32'hAC080000);
        checkOutput("t3_csum", {24'd0, checksum}, 32'h89);

        // Low address bits are ignored.
        applyStimulus(32'h103, 16'd1);
        feedBytes(0, 4, 0);
        waitDone();
        checkOutput("t4_nwe", we_addr.size(), 32'd1);
        checkOutput("t4_addr", we_addr[0], 32'h100);
        checkOutput("t4_csum", {24'd0, checksum}, 32'h2D);

        // Address pointer wraps past the top of memory.
        applyStimulus(32'hFFFFFFFC, 16'd2);
        feedBytes(0, 8, 0);
        waitDone();
        checkOutput("t5_nwe", we_addr.size(), 32'd2);
        checkOutput("t5_addr0", we_addr[0], 32'hFFFFFFFC);
        checkOutput("t5_addr1", we_addr[1], 32'h00000000);
        checkOutput("t5_data1", we_data[1], 32'hAC080000);

        // Zero word count finishes immediately.
        applyStimulus(32'h200, 16'd0);
        checkOutput("t6_done", {31'd0, done}, 32'd1);
        checkOutput("t6_busy", {31'd0, busy}, 32'd0);
        checkOutput("t6_csum", {24'd0, checksum}, 32'd0);
        repeat (4) tick();
        checkOutput("t6_nwe", we_addr.size(), 32'd0);

        // Start while receiving must not disturb the load.
        applyStimulus(32'h300, 16'd1);
        feedBytes(0, 2, 0);
        base_addr  = 32'h500;
        word_count = 16'd3;
        start      = 1'b1;
        tick();
        start      = 1'b0;
        feedBytes(2, 2, 0);
        waitDone();
        repeat (2) tick();
        checkOutput("t7_nwe", we_addr.size(), 32'd1);
        checkOutput("t7_addr", we_addr[0], 32'h300);
        checkOutput("t7_data", we_data[0], 32'h20080005);

        // Reset with a partial word pending.
        loadWords(8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00);
        applyStimulus(32'h400, 16'd1);
        feedBytes(0, 3, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t8_rst_ready", {31'd0, in_ready}, 32'd0);
        checkOutput("t8_rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("t8_rst_csum", {24'd0, checksum}, 32'd0);
        checkOutput("t8_rst_addr", mem_addr, 32'd0);
        checkOutput("t8_rst_wdata", mem_wdata, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (2) tick();
        checkOutput("t8_nwe_after_rst", we_addr.size(), 32'd0);
        checkOutput("t8_idle_done", {31'd0, done}, 32'd0);
        applyStimulus(32'h400, 16'd1);
        feedBytes(0, 4, 0);
        waitDone();
        checkOutput("t8_nwe", we_addr.size(), 32'd1);
        checkOutput("t8_addr", we_addr[0], 32'h400);
        checkOutput("t8_data", we_data[0], 32'h11223344);
        checkOutput("t8_csum", {24'd0, checksum}, 32'h44);

        checkOutput("we_back_to_back", {31'd0, two_we}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
